// File: rtl/switch2x2_router_pkg.sv
// Shared constants for the 2x2 router.
//   Width : default data word width in bits.
package switch2x2_router_pkg;

  localparam int unsigned Width = 8;

endpackage

// File: rtl/switch2x2_router_rr_arb2.sv
// Two-requester round-robin arbiter with a registered preference pointer.
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset (pointer -> 0, input 0 favoured)
//   req_i    : request bits, bit i = input i wants this output
//   accept_i : strobe, the granted request was transferred this cycle
//   grant_o  : one-hot grant (zero when no request)
module switch2x2_router_rr_arb2
  import switch2x2_router_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = ptr_q ? 2'b10 : 2'b01;
    end
  end

  // Prefer the loser next time; only move on an actual transfer.
  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) begin
      ptr_d = ~grant_o[1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/switch2x2_router.sv
// Flow-controlled 2x2 packet router with per-output round-robin arbitration
// and a one-entry valid/ready output register per output.
//   clk_i, rst_i             : clock and synchronous active-high reset
//   inN_valid_i/dest_i/data_i: producer word, dest 0 = out0, 1 = out1
//   inN_ready_o              : word accepted this cycle when valid && ready
//   outN_valid_o/data_o/src_o: held word and the input index it came from
//   outN_ready_i             : consumer takes the word when valid && ready
module switch2x2_router
  import switch2x2_router_pkg::*;
#(
  parameter int unsigned WIDTH = Width
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in0_valid_i,
  input  logic             in0_dest_i,
  input  logic [WIDTH-1:0] in0_data_i,
  output logic             in0_ready_o,
  input  logic             in1_valid_i,
  input  logic             in1_dest_i,
  input  logic [WIDTH-1:0] in1_data_i,
  output logic             in1_ready_o,
  output logic             out0_valid_o,
  output logic [WIDTH-1:0] out0_data_o,
  output logic             out0_src_o,
  input  logic             out0_ready_i,
  output logic             out1_valid_o,
  output logic [WIDTH-1:0] out1_data_o,
  output logic             out1_src_o,
  input  logic             out1_ready_i
);

  localparam logic PortOut0 = 1'b0;
  localparam logic PortOut1 = 1'b1;

  logic [1:0] req0, req1, gnt0, gnt1;
  logic       free0, free1, acc0, acc1;

  logic             out0_valid_q, out0_valid_d, out1_valid_q, out1_valid_d;
  logic [WIDTH-1:0] out0_data_q, out0_data_d, out1_data_q, out1_data_d;
  logic             out0_src_q, out0_src_d, out1_src_q, out1_src_d;

  assign req0 = {in1_valid_i && (in1_dest_i == PortOut0), in0_valid_i && (in0_dest_i == PortOut0)};
  assign req1 = {in1_valid_i && (in1_dest_i == PortOut1), in0_valid_i && (in0_dest_i == PortOut1)};

  // Pipelined ready: a held word leaving this cycle frees the slot.
  assign free0 = !out0_valid_q || out0_ready_i;
  assign free1 = !out1_valid_q || out1_ready_i;

  assign acc0 = !rst_i && free0 && (gnt0 != 2'b00);
  assign acc1 = !rst_i && free1 && (gnt1 != 2'b00);

  assign in0_ready_o = !rst_i && (in0_dest_i ? (gnt1[0] && free1) : (gnt0[0] && free0));
  assign in1_ready_o = !rst_i && (in1_dest_i ? (gnt1[1] && free1) : (gnt0[1] && free0));

  switch2x2_router_rr_arb2 u_arb0 (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req0),
    .accept_i (acc0),
    .grant_o  (gnt0)
  );

  switch2x2_router_rr_arb2 u_arb1 (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req1),
    .accept_i (acc1),
    .grant_o  (gnt1)
  );

  always_comb begin
    out0_valid_d = out0_valid_q;
    out0_data_d  = out0_data_q;
    out0_src_d   = out0_src_q;
    if (acc0) begin
      out0_valid_d = 1'b1;
      out0_data_d  = gnt0[1] ? in1_data_i : in0_data_i;
      out0_src_d   = gnt0[1];
    end else if (free0) begin
      out0_valid_d = 1'b0;
    end
  end

  always_comb begin
    out1_valid_d = out1_valid_q;
    out1_data_d  = out1_data_q;
    out1_src_d   = out1_src_q;
    if (acc1) begin
      out1_valid_d = 1'b1;
      out1_data_d  = gnt1[1] ? in1_data_i : in0_data_i;
      out1_src_d   = gnt1[1];
    end else if (free1) begin
      out1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out0_valid_q <= 1'b0;
      out0_data_q  <= '0;
      out0_src_q   <= 1'b0;
      out1_valid_q <= 1'b0;
      out1_data_q  <= '0;
      out1_src_q   <= 1'b0;
    end else begin
      out0_valid_q <= out0_valid_d;
      out0_data_q  <= out0_data_d;
      out0_src_q   <= out0_src_d;
      out1_valid_q <= out1_valid_d;
      out1_data_q  <= out1_data_d;
      out1_src_q   <= out1_src_d;
    end
  end

  assign out0_valid_o = out0_valid_q;
  assign out0_data_o  = out0_data_q;
  assign out0_src_o   = out0_src_q;
  assign out1_valid_o = out1_valid_q;
  assign out1_data_o  = out1_data_q;
  assign out1_src_o   = out1_src_q;

endmodule
